// File: rtl/wb_cmd_master.sv
`default_nettype none
// ==========================================================================
// wb_cmd_master : valid/ready command port to Wishbone classic master, Rev 1.0
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN for the BUS-state timeout.
// ==========================================================================
module wb_cmd_master #(
  parameter int AW      = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [DW-1:0] cmd_dat_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_we_o,
  output logic          wb_stb_o,
  output logic          wb_cyc_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          cmd_ready_nxt;
  logic          rsp_valid_nxt;
  logic [DW-1:0] rsp_dat_nxt;
  logic          cyc_nxt;
  logic [AW-1:0] wb_adr_nxt;
  logic [DW-1:0] wb_dat_nxt;
  logic          wb_we_nxt;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("wb_cmd_master: TIMEOUT must be within 1..255");
  end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt, to_cnt_nxt;
  logic       rsp_err_nxt;
`endif

  always_comb begin
    state_nxt     = state;
    rsp_valid_nxt = rsp_valid_o;
    rsp_dat_nxt   = rsp_dat_o;
    cyc_nxt       = wb_cyc_o;
    wb_adr_nxt    = wb_adr_o;
    wb_dat_nxt    = wb_dat_o;
    wb_we_nxt     = wb_we_o;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    rsp_err_nxt   = rsp_err_o;
    to_cnt_nxt    = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          wb_adr_nxt = cmd_adr_i;
          wb_dat_nxt = cmd_dat_i;
          wb_we_nxt  = cmd_we_i;
          cyc_nxt    = 1'b1;
          state_nxt  = BUS;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          to_cnt_nxt = 8'd0;
`endif
        end
      end
      BUS: begin
        // Ack beats the timeout when both land on the same edge.
        if (wb_ack_i) begin
          rsp_dat_nxt   = wb_we_o ? '0 : wb_dat_i;
          rsp_valid_nxt = 1'b1;
          cyc_nxt       = 1'b0;
          state_nxt     = RESP;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_err_nxt   = 1'b0;
`endif
        end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          rsp_dat_nxt   = '0;
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = 1'b1;
          cyc_nxt       = 1'b0;
          state_nxt     = RESP;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cmd_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_we_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready_o <= cmd_ready_nxt;
      rsp_valid_o <= rsp_valid_nxt;
      rsp_dat_o   <= rsp_dat_nxt;
      wb_cyc_o    <= cyc_nxt;
      wb_stb_o    <= cyc_nxt;
      wb_adr_o    <= wb_adr_nxt;
      wb_dat_o    <= wb_dat_nxt;
      wb_we_o     <= wb_we_nxt;
    end
  end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt    <= 8'd0;
      rsp_err_o <= 1'b0;
    end else begin
      to_cnt    <= to_cnt_nxt;
      rsp_err_o <= rsp_err_nxt;
    end
  end
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// Testbench for wb_cmd_master: AND/OR register slave with programmable ack delay.
module tb_wb_cmd_master;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TIMEOUT = 15;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [DW-1:0] cmd_dat_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  // Slave: regs 0/1 writable, reg 2 = AND, reg 3 = OR; acks after ack_delay waits.
  logic [7:0]  sregs [0:1] = '{8'h00, 8'h00};
  int unsigned ack_delay = 0;
  int unsigned bus_cnt = 0;
  logic [7:0]  sdat;

  assign wb_ack_i = wb_cyc_o && wb_stb_o && (bus_cnt == ack_delay);
  assign wb_dat_i = sdat;

  always_comb begin
    sdat = 8'h00;
    case (wb_adr_o)
      2'd0: sdat = sregs[0];
      2'd1: sdat = sregs[1];
      2'd2: sdat = sregs[0] & sregs[1];
      default: sdat = sregs[0] | sregs[1];
    endcase
  end

  always @(posedge wb_clk_i) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) bus_cnt <= bus_cnt + 1;
    else bus_cnt <= 0;
    if (wb_ack_i && wb_we_o && wb_adr_o < 2'd2) sregs[wb_adr_o[0]] <= wb_dat_o;
  end

  // Reference model of the register file seen through the bridge.
  logic [7:0] model [0:1] = '{8'h00, 8'h00};

  function automatic logic [7:0] model_rd(input logic [1:0] a);
    if (a == 2'd0) return model[0];
    if (a == 2'd1) return model[1];
    if (a == 2'd2) return model[0] & model[1];
    return model[0] | model[1];
  endfunction

  function automatic logic [7:0] expect_rsp(input logic we, input logic [1:0] a);
    return we ? 8'h00 : model_rd(a);
  endfunction

  task automatic model_wr(input logic we, input logic [1:0] a, input logic [7:0] d);
    if (we && a < 2'd2) model[a[0]] = d;
  endtask

  typedef struct {
    bit         hung;
    logic       got_valid;
    logic [7:0] rdat;
    logic       err;
    int         cyc_cnt;
    bit         unstable;
    bit         held;
    logic       post_valid;
    logic       post_ready;
  } obs_t;

  // Runs one command and records what the DUT did; callers judge the record.
  task automatic do_cmd(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                        input int unsigned delay, input int unsigned bp, output obs_t o);
    int w;
    o = '{hung: 1'b0, got_valid: 1'b0, rdat: 8'h00, err: 1'b0, cyc_cnt: 0,
          unstable: 1'b0, held: 1'b1, post_valid: 1'b0, post_ready: 1'b0};
    w = 0;
    while (cmd_ready_o !== 1'b1 && w < 50) begin
      @(negedge wb_clk_i);
      w++;
    end
    if (cmd_ready_o !== 1'b1) begin
      o.hung = 1'b1;
      return;
    end
    ack_delay   = delay;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_valid_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    cmd_dat_i   = 8'($urandom);
    cmd_adr_i   = 2'($urandom);
    for (int i = 0; i < 300 && wb_cyc_o === 1'b1; i++) begin
      o.cyc_cnt++;
      if (wb_stb_o !== 1'b1 || wb_adr_o !== adr || wb_dat_o !== dat || wb_we_o !== we)
        o.unstable = 1'b1;
      @(negedge wb_clk_i);
    end
    if (wb_cyc_o !== 1'b0) o.hung = 1'b1;
    o.got_valid = rsp_valid_o;
    o.rdat      = rsp_dat_o;
    o.err       = rsp_err_o;
    for (int i = 0; i < int'(bp); i++) begin
      @(negedge wb_clk_i);
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== o.rdat || rsp_err_o !== o.err ||
          cmd_ready_o !== 1'b0 || wb_cyc_o !== 1'b0)
        o.held = 1'b0;
    end
    rsp_ready_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    rsp_ready_i  = 1'b0;
    o.post_valid = rsp_valid_o;
    o.post_ready = cmd_ready_o;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if (cmd_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl ready=%b valid=%b err=%b required 0 0 0", cmd_ready_o, rsp_valid_o, rsp_err_o);
    end
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus cyc=%b stb=%b we=%b required 0 0 0", wb_cyc_o, wb_stb_o, wb_we_o);
    end
    checks++;
    if (wb_adr_o !== 2'd0 || wb_dat_o !== 8'h00 || rsp_dat_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_data adr=%h dat=%h rsp_dat=%h required 0", wb_adr_o, wb_dat_o, rsp_dat_o);
    end
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", cmd_ready_o);
    end
  endtask

  task automatic test_write_readback;
    obs_t o;
    logic [7:0] exp_v;
    logic        we_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  ad_t [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0]  dt_t [4] = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    logic [7:0]  rd_t [4] = '{8'h00, 8'h00, 8'h24, 8'hBD};
    for (int i = 0; i < 4; i++) begin
      do_cmd(we_t[i], ad_t[i], dt_t[i], 0, 0, o);
      model_wr(we_t[i], ad_t[i], dt_t[i]);
      exp_v = expect_rsp(we_t[i], ad_t[i]);
      checks++;
      if (o.hung || o.got_valid !== 1'b1 || o.rdat !== rd_t[i] || o.rdat !== exp_v || o.err !== 1'b0) begin
        errors++;
        $display("FAIL wr_rd_%0d hung=%0d valid=%b dat=%h err=%b required valid=1 dat=%h err=0",
                 i, o.hung, o.got_valid, o.rdat, o.err, rd_t[i]);
      end
      checks++;
      if (o.cyc_cnt != 1 || o.unstable) begin
        errors++;
        $display("FAIL wr_rd_cyc_%0d cyc_cycles=%0d unstable=%0d required 1 0", i, o.cyc_cnt, o.unstable);
      end
    end
  endtask

  task automatic test_wait_states;
    obs_t o;
    do_cmd(1'b1, 2'd0, 8'h5A, 0, 0, o);
    model_wr(1'b1, 2'd0, 8'h5A);
    do_cmd(1'b0, 2'd0, 8'h00, 3, 0, o);
    checks++;
    if (o.cyc_cnt != 4 || o.unstable) begin
      errors++;
      $display("FAIL wait_cyc cyc_cycles=%0d unstable=%0d required 4 0", o.cyc_cnt, o.unstable);
    end
    checks++;
    if (o.got_valid !== 1'b1 || o.rdat !== 8'h5A || o.err !== 1'b0) begin
      errors++;
      $display("FAIL wait_data valid=%b dat=%h err=%b required 1 5a 0", o.got_valid, o.rdat, o.err);
    end
  endtask

  task automatic test_backpressure;
    obs_t o;
    do_cmd(1'b0, 2'd3, 8'h00, 0, 5, o);
    checks++;
    if (o.got_valid !== 1'b1 || o.rdat !== model_rd(2'd3) || !o.held) begin
      errors++;
      $display("FAIL bp_hold valid=%b dat=%h held=%0d required 1 %h 1", o.got_valid, o.rdat, o.held, model_rd(2'd3));
    end
    checks++;
    if (o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release valid=%b ready=%b required 0 1", o.post_valid, o.post_ready);
    end
  endtask

  task automatic test_back_to_back;
    int hs = 0;
    int rv = 0;
    ack_delay   = 0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 2'd3;
    cmd_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready_o === 1'b1) hs++;
      if (rsp_valid_o === 1'b1) rv++;
      @(negedge wb_clk_i);
    end
    cmd_valid_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    checks++;
    if (hs != 4 || rv != 4) begin
      errors++;
      $display("FAIL b2b_rate handshakes=%0d responses=%0d required 4 4 in 12 cycles", hs, rv);
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic we;
    logic [1:0] a;
    logic [7:0] d, exp_v;
    int unsigned dl, bp;
    int bad = 0;
    for (int i = 0; i < 25; i++) begin
      we = 1'($urandom);
      a  = 2'($urandom);
      d  = 8'($urandom);
      dl = $urandom_range(0, 3);
      bp = $urandom_range(0, 2);
      do_cmd(we, a, d, dl, bp, o);
      model_wr(we, a, d);
      exp_v = expect_rsp(we, a);
      checks++;
      if (o.hung || o.got_valid !== 1'b1 || o.rdat !== exp_v || o.err !== 1'b0 ||
          o.cyc_cnt != int'(dl) + 1 || o.unstable || !o.held ||
          o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 6)
          $display("FAIL rand_%0d we=%b adr=%0d dat=%h err=%b cyc=%0d got_valid=%b hung=%0d required dat=%h err=0 cyc=%0d",
                   i, we, a, o.rdat, o.err, o.cyc_cnt, o.got_valid, o.hung, exp_v, dl + 1);
      end
    end
  endtask

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    obs_t o;
    do_cmd(1'b0, 2'd2, 8'h00, 1000, 0, o);
    checks++;
    if (o.cyc_cnt != TIMEOUT || o.unstable) begin
      errors++;
      $display("FAIL to_cyc cyc_cycles=%0d unstable=%0d required %0d 0", o.cyc_cnt, o.unstable, TIMEOUT);
    end
    checks++;
    if (o.got_valid !== 1'b1 || o.err !== 1'b1 || o.rdat !== 8'h00) begin
      errors++;
      $display("FAIL to_rsp valid=%b err=%b dat=%h required 1 1 00", o.got_valid, o.err, o.rdat);
    end
    do_cmd(1'b0, 2'd3, 8'h00, 0, 0, o);
    checks++;
    if (o.got_valid !== 1'b1 || o.err !== 1'b0 || o.rdat !== model_rd(2'd3) || o.cyc_cnt != 1) begin
      errors++;
      $display("FAIL to_next err=%b dat=%h cyc=%0d required 0 %h 1", o.err, o.rdat, o.cyc_cnt, model_rd(2'd3));
    end
    do_cmd(1'b0, 2'd1, 8'h00, TIMEOUT - 1, 0, o);
    checks++;
    if (o.got_valid !== 1'b1 || o.err !== 1'b0 || o.rdat !== model_rd(2'd1) || o.cyc_cnt != TIMEOUT) begin
      errors++;
      $display("FAIL to_limit_ack err=%b dat=%h cyc=%0d required 0 %h %0d", o.err, o.rdat, o.cyc_cnt, model_rd(2'd1), TIMEOUT);
    end
  endtask
`endif

  task automatic test_reset_in_bus;
    int vis = 0;
    ack_delay   = 10;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 2'd0;
    cmd_valid_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_bus_abort cyc=%b stb=%b required 0 0", wb_cyc_o, wb_stb_o);
    end
    @(negedge wb_clk_i);
    checks++;
    if (cmd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_bus_ready_in_reset got %b required 0", cmd_ready_o);
    end
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_bus_ready_after got %b required 1", cmd_ready_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_o !== 1'b0 || wb_cyc_o !== 1'b0) vis++;
      @(negedge wb_clk_i);
    end
    checks++;
    if (vis != 0) begin
      errors++;
      $display("FAIL rst_bus_no_rsp active_cycles=%0d required 0", vis);
    end
    ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_wait_states();
    test_backpressure();
    test_back_to_back();
    test_random();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
